// File: rtl/fp_divsqrt_arbiter.sv
// fp_divsqrt_arbiter: round-robin front end that shares one iterative FP
// div/sqrt unit among NUM_REQ requesters. One operation is in flight at a time;
// its registered result is returned to the originating requester.
//
// Handshakes: a request is consumed in the cycle its gnt_o bit is high
// (gnt_o is combinational, valid only while the unit reports du_ready_i).
// A result is offered with rvalid_o[owner] and retired on the edge where
// rready_i[owner] is also high; res_o/status_o/tag_o stay stable until then.
module fp_divsqrt_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int FP_WIDTH   = 32,
   parameter int TAG_WIDTH  = 4,
   parameter int RND_WIDTH  = 3,
   parameter int STAT_WIDTH = 5
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ*FP_WIDTH-1:0]    op_a_i,
   input  logic [NUM_REQ*FP_WIDTH-1:0]    op_b_i,
   input  logic [NUM_REQ-1:0]             sqrt_sel_i,
   input  logic [NUM_REQ*RND_WIDTH-1:0]   rnd_i,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]   tag_i,
   output logic [NUM_REQ-1:0]             gnt_o,
   output logic [NUM_REQ-1:0]             rvalid_o,
   input  logic [NUM_REQ-1:0]             rready_i,
   output logic [FP_WIDTH-1:0]            res_o,
   output logic [STAT_WIDTH-1:0]          status_o,
   output logic [TAG_WIDTH-1:0]           tag_o,
   output logic                           du_en_o,
   output logic [FP_WIDTH-1:0]            du_op_a_o,
   output logic [FP_WIDTH-1:0]            du_op_b_o,
   output logic                           du_sqrt_sel_o,
   output logic [RND_WIDTH-1:0]           du_rnd_o,
   input  logic                           du_ready_i,
   input  logic                           du_valid_i,
   input  logic [FP_WIDTH-1:0]            du_res_i,
   input  logic [STAT_WIDTH-1:0]          du_status_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]       owner_q, owner_d;
   logic [TAG_WIDTH-1:0]   owner_tag_q, owner_tag_d;
   logic [FP_WIDTH-1:0]    res_q, res_d;
   logic [STAT_WIDTH-1:0]  status_q, status_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;

   logic [PTR_W-1:0]       win;
   logic [PTR_W-1:0]       idx_w;
   logic                   found;
   logic                   grant;
   int                     idx;

   // Round-robin search: first active request at or after rr_ptr_q, wrapping.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         idx_w = PTR_W'(idx);
         if (!found && req_i[idx_w]) begin
            found = 1'b1;
            win   = idx_w;
         end
      end
   end

   assign grant = (state_q == IDLE) && found && du_ready_i;

   // Grant and unit-side issue; data outputs are zeroed whenever nothing is issued.
   always_comb begin
      gnt_o         = '0;
      du_en_o       = 1'b0;
      du_op_a_o     = '0;
      du_op_b_o     = '0;
      du_sqrt_sel_o = 1'b0;
      du_rnd_o      = '0;
      if (grant) begin
         gnt_o[win]    = 1'b1;
         du_en_o       = 1'b1;
         du_op_a_o     = op_a_i[int'(win)*FP_WIDTH +: FP_WIDTH];
         du_op_b_o     = op_b_i[int'(win)*FP_WIDTH +: FP_WIDTH];
         du_sqrt_sel_o = sqrt_sel_i[win];
         du_rnd_o      = rnd_i[int'(win)*RND_WIDTH +: RND_WIDTH];
      end
   end

   // Next-state: issue in IDLE, capture the done pulse in BUSY, retire in RESP.
   // A done pulse outside BUSY is spurious and leaves every register untouched.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      owner_tag_d = owner_tag_q;
      res_d       = res_q;
      status_d    = status_q;
      tag_d       = tag_q;
      rvalid_d    = rvalid_q;
      case (state_q)
         IDLE: begin
            if (grant) begin
               owner_d     = win;
               owner_tag_d = tag_i[int'(win)*TAG_WIDTH +: TAG_WIDTH];
               rr_ptr_d    = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + PTR_W'(1);
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (du_valid_i) begin
               res_d             = du_res_i;
               status_d          = du_status_i;
               tag_d             = owner_tag_q;
               rvalid_d          = '0;
               rvalid_d[owner_q] = 1'b1;
               state_d           = RESP;
            end
         end
         RESP: begin
            if (rready_i[owner_q]) begin
               rvalid_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset discards any in-flight operation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         owner_tag_q <= '0;
         res_q       <= '0;
         status_q    <= '0;
         tag_q       <= '0;
         rvalid_q    <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         owner_tag_q <= owner_tag_d;
         res_q       <= res_d;
         status_q    <= status_d;
         tag_q       <= tag_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign res_o    = res_q;
   assign status_o = status_q;
   assign tag_o    = tag_q;

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Bench for fp_divsqrt_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_fp_divsqrt_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int TW = 4;
   localparam int RW = 3;
   localparam int SW = 5;

   // ---------------- clock / reset / signals ----------------
   logic            clk = 1'b0;
   logic            rst_i;
   logic [N-1:0]    req_i;
   logic [N*W-1:0]  op_a_i, op_b_i;
   logic [N-1:0]    sqrt_sel_i;
   logic [N*RW-1:0] rnd_i;
   logic [N*TW-1:0] tag_i;
   logic [N-1:0]    gnt_o, rvalid_o, rready_i;
   logic [W-1:0]    res_o;
   logic [SW-1:0]   status_o;
   logic [TW-1:0]   tag_o;
   logic            du_en_o;
   logic [W-1:0]    du_op_a_o, du_op_b_o;
   logic            du_sqrt_sel_o;
   logic [RW-1:0]   du_rnd_o;
   logic            du_ready_i, du_valid_i;
   logic [W-1:0]    du_res_i;
   logic [SW-1:0]   du_status_i;

   always #5 clk = ~clk;

   fp_divsqrt_arbiter #(.NUM_REQ(N), .FP_WIDTH(W), .TAG_WIDTH(TW),
                        .RND_WIDTH(RW), .STAT_WIDTH(SW)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
      .sqrt_sel_i(sqrt_sel_i), .rnd_i(rnd_i), .tag_i(tag_i), .gnt_o(gnt_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i), .res_o(res_o), .status_o(status_o),
      .tag_o(tag_o), .du_en_o(du_en_o), .du_op_a_o(du_op_a_o), .du_op_b_o(du_op_b_o),
      .du_sqrt_sel_o(du_sqrt_sel_o), .du_rnd_o(du_rnd_o), .du_ready_i(du_ready_i),
      .du_valid_i(du_valid_i), .du_res_i(du_res_i), .du_status_i(du_status_i));

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] onehot(int k);
      logic [N-1:0] r;
      r    = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 = free, 1 = unit computing, 2 = result waiting for its requester
   int             m_phase;
   int             m_last;     // requester granted most recently (lowest priority)
   int             m_owner;
   int             m_win;
   logic [TW-1:0]  m_otag, m_tag;
   logic [W-1:0]   m_res;
   logic [SW-1:0]  m_stat;
   logic [N-1:0]   m_rvalid;
   int             unit_cnt;
   logic [TW+1:0]  exp_q[$];   // {owner, tag} of each issued operation

   task automatic model_reset();
      m_phase  = 0;
      m_last   = N - 1;
      m_owner  = 0;
      m_otag   = '0;
      m_tag    = '0;
      m_res    = '0;
      m_stat   = '0;
      m_rvalid = '0;
      exp_q.delete();
   endtask

   // Priority goes to the requester just after the last one granted.
   function automatic int pick(logic [N-1:0] r);
      for (int off = 1; off <= N; off++) begin
         if (r[(m_last + off) % N]) return (m_last + off) % N;
      end
      return -1;
   endfunction

   // Compare every output against the model for the current cycle's inputs.
   task automatic eval();
      logic [TW+1:0] e;
      #1;
      m_win = (m_phase == 0 && du_ready_i && (|req_i)) ? pick(req_i) : -1;
      check("gnt", gnt_o, (m_win >= 0) ? onehot(m_win) : '0);
      check("du_en", du_en_o, m_win >= 0);
      check("du_op_a", du_op_a_o, (m_win >= 0) ? op_a_i[m_win*W +: W] : '0);
      check("du_op_b", du_op_b_o, (m_win >= 0) ? op_b_i[m_win*W +: W] : '0);
      check("du_sqrt", du_sqrt_sel_o, (m_win >= 0) ? sqrt_sel_i[m_win] : 1'b0);
      check("du_rnd", du_rnd_o, (m_win >= 0) ? rnd_i[m_win*RW +: RW] : '0);
      check("rvalid", rvalid_o, m_rvalid);
      check("res", res_o, m_res);
      check("status", status_o, m_stat);
      check("tag", tag_o, m_tag);
      if (!rst_i && m_phase == 2 && rready_i[m_owner]) begin
         if (exp_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            check("sb_tag", tag_o, e[TW-1:0]);
            check("sb_owner", rvalid_o, onehot(int'(e[TW+1:TW])));
         end
      end
   endtask

   // Let the clock edge happen and move the model accordingly.
   task automatic advance();
      @(posedge clk);
      if (rst_i) begin
         model_reset();
      end else begin
         case (m_phase)
            0: if (m_win >= 0) begin
                  m_owner  = m_win;
                  m_last   = m_win;
                  m_otag   = tag_i[m_win*TW +: TW];
                  m_phase  = 1;
                  unit_cnt = $urandom_range(0, 5);
                  exp_q.push_back({2'(m_win), m_otag});
               end
            1: if (du_valid_i) begin
                  m_res    = du_res_i;
                  m_stat   = du_status_i;
                  m_tag    = m_otag;
                  m_rvalid = onehot(m_owner);
                  m_phase  = 2;
               end
            default: if (rready_i[m_owner]) begin
                  m_rvalid = '0;
                  m_phase  = 0;
               end
         endcase
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick_in();
      @(negedge clk);
      rst_i      = 1'b0;
      du_valid_i = 1'b0;
   endtask

   task automatic set_idle();
      req_i = '0; op_a_i = '0; op_b_i = '0; sqrt_sel_i = '0; rnd_i = '0; tag_i = '0;
      rready_i = '0; du_ready_i = 1'b1; du_valid_i = 1'b0; du_res_i = '0; du_status_i = '0;
   endtask

   task automatic do_reset();
      tick_in();
      set_idle();
      rst_i = 1'b1;
      eval();
      advance();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [N-1:0] oh;
      rst_i = 1'b1;
      set_idle();
      model_reset();
      unit_cnt = 0;
      do_reset();

      // Reset state
      tick_in();
      eval();
      check("rst_rvalid", rvalid_o, 0);
      check("rst_res", res_o, 0);
      check("rst_gnt", gnt_o, 0);
      advance();

      // Single request from requester 2: 10.0 / 2.0, tag 3
      tick_in();
      req_i = 4'b0100;
      op_a_i[2*W +: W] = 32'h4120_0000;
      op_b_i[2*W +: W] = 32'h4000_0000;
      tag_i[2*TW +: TW] = 4'd3;
      eval();
      check("single_gnt", gnt_o, 4'b0100);
      check("single_en", du_en_o, 1);
      check("single_op_a", du_op_a_o, 32'h4120_0000);
      advance();
      for (int i = 0; i < 2; i++) begin
         tick_in(); req_i = '0; eval();
         check("single_en_once", du_en_o, 0);
         advance();
      end
      tick_in(); du_valid_i = 1'b1; du_res_i = 32'h40A0_0000; du_status_i = '0; eval(); advance();
      for (int i = 0; i < 2; i++) begin
         tick_in(); eval();
         check("single_rvalid", rvalid_o, 4'b0100);
         check("single_res", res_o, 32'h40A0_0000);
         check("single_tag", tag_o, 4'd3);
         advance();
      end
      tick_in(); rready_i = 4'b0100; eval(); advance();
      tick_in(); rready_i = '0; eval(); check("single_retired", rvalid_o, 0); advance();

      // Round-robin from reset with all four requesting
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick_in(); req_i = '1; tag_i = 16'($urandom); du_ready_i = 1'b1; rready_i = '0; eval();
         oh = '0; oh[i % N] = 1'b1;
         check("rr_order", gnt_o, oh);
         advance();
         tick_in(); eval(); advance();
         tick_in(); du_valid_i = 1'b1; du_res_i = $urandom; eval(); advance();
         tick_in(); rready_i = '1; eval(); advance();
      end

      // Unit not ready for five cycles
      for (int i = 0; i < 5; i++) begin
         tick_in(); req_i = 4'b0001; tag_i = 16'h5A3C; rready_i = '0; du_ready_i = 1'b0; eval();
         check("nrdy_gnt", gnt_o, 0);
         check("nrdy_en", du_en_o, 0);
         advance();
      end
      tick_in(); du_ready_i = 1'b1; eval(); check("nrdy_then_gnt", gnt_o, 4'b0001); advance();
      tick_in(); du_valid_i = 1'b1; du_res_i = 32'h3F80_0000; du_status_i = 5'h01; eval(); advance();

      // Back-pressure: owner 0 holds off, others say ready, unit keeps pulsing
      for (int i = 0; i < 10; i++) begin
         tick_in(); req_i = '1; rready_i = 4'b1110;
         du_valid_i = 1'b1; du_res_i = $urandom; du_status_i = 5'($urandom);
         eval();
         check("bp_res", res_o, 32'h3F80_0000);
         check("bp_status", status_o, 5'h01);
         check("bp_tag", tag_o, 4'hC);
         check("bp_gnt", gnt_o, 0);
         advance();
      end
      tick_in(); req_i = '0; rready_i = 4'b0001; eval(); advance();
      tick_in(); rready_i = '0; eval(); check("bp_retired", rvalid_o, 0); advance();

      // Spurious done in IDLE
      do_reset();
      tick_in(); du_valid_i = 1'b1; du_res_i = 32'hDEAD_BEEF; eval(); advance();
      tick_in(); eval();
      check("spur_res", res_o, 0);
      check("spur_rvalid", rvalid_o, 0);
      advance();

      // Reset while BUSY
      tick_in(); req_i = 4'b0100; eval(); check("rb_gnt", gnt_o, 4'b0100); advance();
      tick_in(); req_i = '0; eval(); advance();
      tick_in(); rst_i = 1'b1; eval(); advance();
      tick_in(); req_i = 4'b1010; eval();
      check("rb_gnt_after", gnt_o, 4'b0010);
      check("rb_rvalid", rvalid_o, 0);
      check("rb_res", res_o, 0);
      advance();

      // Randomized traffic with a unit model of variable latency
      for (int c = 0; c < 3000; c++) begin
         tick_in();
         rst_i       = ($urandom_range(0, 299) == 0);
         req_i       = 4'($urandom);
         op_a_i      = {$urandom, $urandom, $urandom, $urandom};
         op_b_i      = {$urandom, $urandom, $urandom, $urandom};
         sqrt_sel_i  = 4'($urandom);
         rnd_i       = 12'($urandom);
         tag_i       = 16'($urandom);
         du_ready_i  = ($urandom_range(0, 3) != 0);
         rready_i    = 4'($urandom);
         du_res_i    = $urandom;
         du_status_i = 5'($urandom);
         if (m_phase == 1) begin
            if (unit_cnt == 0) du_valid_i = 1'b1;
            else unit_cnt--;
         end else begin
            du_valid_i = ($urandom_range(0, 7) == 0);
         end
         eval();
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_divsqrt_arbiter.md
Name: fp_divsqrt_arbiter

Overview:
- Shares one iterative FP div/sqrt unit among NUM_REQ requesters, such as the cores of a cluster.
- Performs round-robin arbitration and issues the winner's operation to the unit.
- Tracks the single in-flight operation and returns the registered result, status and tag to the originating requester with a valid/ready handshake.
- Sits between the cluster APU interconnect and the div/sqrt wrapper.

Parameters:
- NUM_REQ, 4: number of requesters, minimum 2.
- FP_WIDTH, 32: operand and result width.
- TAG_WIDTH, 4: per-request tag width, minimum 1.
- RND_WIDTH, 3: rounding-mode field width.
- STAT_WIDTH, 5: status-flag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NUM_REQ  request per requester.
- op_a_i  in  NUM_REQ*FP_WIDTH  operand A; requester k uses slice k.
- op_b_i  in  NUM_REQ*FP_WIDTH  operand B; requester k uses slice k.
- sqrt_sel_i  in  NUM_REQ  1 = sqrt, 0 = div.
- rnd_i  in  NUM_REQ*RND_WIDTH  rounding mode.
- tag_i  in  NUM_REQ*TAG_WIDTH  request tag.
- gnt_o  out  NUM_REQ  one-hot grant, combinational.
- rvalid_o  out  NUM_REQ  one-hot result valid.
- rready_i  in  NUM_REQ  result accept.
- res_o  out  FP_WIDTH  result, shared by all requesters.
- status_o  out  STAT_WIDTH  status flags.
- tag_o  out  TAG_WIDTH  tag of the returned request.
- du_en_o  out  1  start pulse to the unit.
- du_op_a_o  out  FP_WIDTH  operand A to the unit.
- du_op_b_o  out  FP_WIDTH  operand B to the unit.
- du_sqrt_sel_o  out  1  operation select to the unit.
- du_rnd_o  out  RND_WIDTH  rounding mode to the unit.
- du_ready_i  in  1  unit idle and able to accept a start.
- du_valid_i  in  1  one-cycle done pulse from the unit.
- du_res_i  in  FP_WIDTH  result from the unit.
- du_status_i  in  STAT_WIDTH  status from the unit.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state = IDLE, rr_ptr = 0, owner = 0.
  - res_o, status_o, tag_o, the owner tag register and all rvalid_o bits = 0.
  - Combinational outputs in IDLE with no request: gnt_o = 0, du_en_o = 0, du_* data = 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If |req_i and du_ready_i: winner = first k with req_i[k]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - Same cycle: gnt_o[winner]=1, du_en_o=1, du_* = winner's slices.
  - At the edge: owner <= winner, owner tag <= tag_i[winner], rr_ptr <= (winner+1) mod NUM_REQ, go to BUSY.
  - If du_ready_i=0: no grant, du_en_o=0, stay in IDLE.
  - In all non-granting cycles du_* data outputs = 0.
- A request is consumed in the cycle its gnt_o bit is 1. A requester may drop req_i before it is granted, with no side effect.
- BUSY:
  - gnt_o=0, du_en_o=0.
  - On du_valid_i=1: res_o <= du_res_i, status_o <= du_status_i, tag_o <= owner tag, go to RESP.
- RESP:
  - rvalid_o[owner]=1 (registered, asserted from the first RESP cycle). res_o, status_o and tag_o are held stable.
  - On rready_i[owner]=1: rvalid_o cleared at that edge, go to IDLE.
  - rready_i bits of non-owners are ignored. No new grant is issued in RESP, so back-to-back operations have a minimum 1-cycle bubble.
- du_valid_i in IDLE or RESP is spurious and ignored: no register update, no state change.
- Latency: grant edge -> du_valid_i after N cycles -> rvalid_o on the next cycle. res_o stays valid until the requester accepts.
- Fairness: the requester granted last has lowest priority next time. With all NUM_REQ requesting continuously, each is granted once per NUM_REQ operations.
- Reset mid-operation (BUSY or RESP): return to IDLE with reset values; any in-flight result is discarded. The div/sqrt unit shares rst_i and is reset in the same cycle.
- At most one operation is in flight at any time. gnt_o and rvalid_o are always zero- or one-hot.

Test Plan:
- Single request: req_i=4'b0100, op_a=0x41200000 (10.0), op_b=0x40000000 (2.0), div, tag=3 -> gnt_o=4'b0100 and du_en_o=1 for exactly one cycle; after du_valid_i, rvalid_o=4'b0100, res_o=0x40A00000, tag_o=3; held until rready_i[2].
- Round-robin: req_i=4'b1111 held for 8 operations from reset -> grant order 0,1,2,3,0,1,2,3.
- Unit not ready: req_i=4'b0001 with du_ready_i=0 for 5 cycles -> gnt_o=0 and du_en_o=0 for those 5 cycles; grant in the first cycle du_ready_i=1.
- Back-pressure: in RESP, hold rready_i[owner]=0 for 10 cycles while pulsing du_valid_i with new data and asserting rready_i of non-owners -> res_o, status_o and tag_o unchanged; no new grant; returns to IDLE only on rready_i[owner].
- Spurious done: du_valid_i=1 in IDLE with du_res_i=0xDEADBEEF -> res_o stays 0 and no rvalid_o asserted.
- Reset in BUSY: rst_i=1 for one cycle -> next cycle state IDLE, rvalid_o=0, res_o=0, rr_ptr=0; a subsequent req_i=4'b1010 grants requester 1.
